// File: rtl/spu32_cpu_lsu_pkg.sv
// Shared definitions for the SPU32 load/store unit: bus operation codes,
// FSM state encoding and access-shape helpers.
package spu32_cpu_lsu_pkg;

    // Opcodes match the ones produced by the existing instruction decoder.
    localparam logic [2:0] BUSOP_READB  = 3'b000;
    localparam logic [2:0] BUSOP_READBU = 3'b001;
    localparam logic [2:0] BUSOP_READH  = 3'b010;
    localparam logic [2:0] BUSOP_READHU = 3'b011;
    localparam logic [2:0] BUSOP_READW  = 3'b100;
    localparam logic [2:0] BUSOP_WRITEB = 3'b101;
    localparam logic [2:0] BUSOP_WRITEH = 3'b110;
    localparam logic [2:0] BUSOP_WRITEW = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_STEP   = 2'd2,
        ST_DONE   = 2'd3
    } lsu_state_t;

    function automatic logic op_is_write(input logic [2:0] op);
        return (op == BUSOP_WRITEB) || (op == BUSOP_WRITEH) || (op == BUSOP_WRITEW);
    endfunction

    function automatic logic op_is_half(input logic [2:0] op);
        return (op == BUSOP_READH) || (op == BUSOP_READHU) || (op == BUSOP_WRITEH);
    endfunction

    function automatic logic op_is_word(input logic [2:0] op);
        return (op == BUSOP_READW) || (op == BUSOP_WRITEW);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        return (op_is_half(op) && addr_lo[0]) || (op_is_word(op) && (addr_lo != 2'b00));
    endfunction

    // Index of the final byte beat when an access is split.
    function automatic logic [1:0] split_last_beat(input logic [2:0] op);
        return op_is_word(op) ? 2'd3 : (op_is_half(op) ? 2'd1 : 2'd0);
    endfunction

endpackage

// File: rtl/spu32_cpu_lsu_extend.sv
// Op-driven sign/zero extension of a right-aligned read result.
module spu32_cpu_lsu_extend
    import spu32_cpu_lsu_pkg::*;
(
    input  logic [2:0]  I_op,
    input  logic [31:0] I_data,
    output logic [31:0] O_data
);

    always_comb begin
        O_data = I_data;
        case (I_op)
            BUSOP_READB:  O_data = {{24{I_data[7]}}, I_data[7:0]};
            BUSOP_READBU: O_data = {24'b0, I_data[7:0]};
            BUSOP_READH:  O_data = {{16{I_data[15]}}, I_data[15:0]};
            BUSOP_READHU: O_data = {16'b0, I_data[15:0]};
            default:      O_data = I_data;
        endcase
    end

endmodule

// File: rtl/spu32_cpu_lsu.sv
// SPU32 load/store unit: registered bus master with per-beat timeout.
// Optional macro MISALIGN_SPLIT_EN splits misaligned half/word accesses into byte beats.
module spu32_cpu_lsu
    import spu32_cpu_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  I_clk,
    input  logic                  I_reset_n,
    input  logic                  I_en,
    input  logic [2:0]            I_op,
    input  logic [ADDR_WIDTH-1:0] I_addr,
    input  logic [31:0]           I_data,
    output logic [31:0]           O_data,
    output logic                  O_busy,
    output logic                  O_valid,
    output logic                  O_err,
    output logic                  O_misaligned,
    output logic [ADDR_WIDTH-1:0] O_bus_addr,
    output logic [31:0]           O_bus_data,
    output logic                  O_bus_strobe,
    output logic                  O_bus_write,
    output logic                  O_bus_halfword,
    output logic                  O_bus_fullword,
    input  logic [31:0]           I_bus_data,
    input  logic                  I_bus_wait,
    output lsu_state_t            O_state
);

`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    localparam int WCW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int WAIT_LIMIT = (TIMEOUT > 0) ? TIMEOUT : 1;

    lsu_state_t     state, state_next;
    logic [2:0]     op_q;
    logic [31:0]    data_q;
    logic [31:0]    rdata_asm;
    logic [31:0]    asm_next;
    logic [31:0]    ext_data;
    logic [1:0]     beat_q;
    logic [1:0]     last_beat;
    logic [WCW-1:0] wait_cnt;
    logic           split_q;
    logic           err_q;
    logic           mis_q;
    logic           misal_in;
    logic           timed_out;
    logic           last;

    assign misal_in  = is_misaligned(I_op, I_addr[1:0]);
    assign last      = (beat_q == last_beat);
    assign timed_out = (TIMEOUT > 0) && (state == ST_ACCESS) && I_bus_wait
                       && (int'(wait_cnt) >= TIMEOUT - 1);

    assign O_state      = state;
    assign O_busy       = (state != ST_IDLE);
    assign O_valid      = (state == ST_DONE) && !err_q && !mis_q;
    assign O_err        = (state == ST_DONE) && err_q;
    assign O_misaligned = (state == ST_DONE) && mis_q;

    // Split reads drop each byte beat into its little-endian lane.
    always_comb begin
        asm_next = I_bus_data;
        if (split_q) begin
            asm_next = rdata_asm;
            asm_next[{beat_q, 3'b000} +: 8] = I_bus_data[7:0];
        end
    end

    spu32_cpu_lsu_extend u_extend (
        .I_op   (op_q),
        .I_data (asm_next),
        .O_data (ext_data)
    );

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) state <= ST_IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (I_en) state_next = (misal_in && !SPLIT_EN) ? ST_DONE : ST_ACCESS;
            ST_ACCESS: begin
                if (timed_out)        state_next = ST_DONE;
                else if (!I_bus_wait) state_next = last ? ST_DONE : ST_STEP;
            end
            ST_STEP:   state_next = ST_ACCESS;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            op_q           <= '0;
            data_q         <= '0;
            rdata_asm      <= '0;
            beat_q         <= '0;
            last_beat      <= '0;
            wait_cnt       <= '0;
            split_q        <= 1'b0;
            err_q          <= 1'b0;
            mis_q          <= 1'b0;
            O_data         <= '0;
            O_bus_addr     <= '0;
            O_bus_data     <= '0;
            O_bus_strobe   <= 1'b0;
            O_bus_write    <= 1'b0;
            O_bus_halfword <= 1'b0;
            O_bus_fullword <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (I_en) begin
                    op_q      <= I_op;
                    data_q    <= I_data;
                    rdata_asm <= '0;
                    beat_q    <= '0;
                    wait_cnt  <= '0;
                    err_q     <= 1'b0;
                    mis_q     <= misal_in && !SPLIT_EN;
                    split_q   <= misal_in && SPLIT_EN;
                    last_beat <= (misal_in && SPLIT_EN) ? split_last_beat(I_op) : 2'd0;
                    if (!misal_in || SPLIT_EN) begin
                        O_bus_strobe   <= 1'b1;
                        O_bus_addr     <= I_addr;
                        O_bus_write    <= op_is_write(I_op);
                        O_bus_halfword <= op_is_half(I_op) && !misal_in;
                        O_bus_fullword <= op_is_word(I_op) && !misal_in;
                        O_bus_data     <= misal_in ? {24'b0, I_data[7:0]} : I_data;
                    end
                end
                ST_ACCESS: begin
                    if (timed_out) begin
                        O_bus_strobe <= 1'b0;
                        err_q        <= 1'b1;
                        O_data       <= '0;
                    end else if (I_bus_wait) begin
                        if (int'(wait_cnt) < WAIT_LIMIT) wait_cnt <= wait_cnt + 1'b1;
                    end else begin
                        O_bus_strobe <= 1'b0;
                        rdata_asm    <= asm_next;
                        wait_cnt     <= '0;
                        if (last) begin
                            if (!op_is_write(op_q)) O_data <= ext_data;
                        end else begin
                            beat_q     <= beat_q + 2'd1;
                            O_bus_addr <= O_bus_addr + 1'b1;
                            O_bus_data <= {24'b0, data_q[{beat_q + 2'd1, 3'b000} +: 8]};
                        end
                    end
                end
                ST_STEP: O_bus_strobe <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spu32_cpu_lsu.sv
// Directed self-checking bench for spu32_cpu_lsu (TIMEOUT=4, 32-bit addresses).
module tb_spu32_cpu_lsu;
    import spu32_cpu_lsu_pkg::*;

    logic        I_clk = 1'b0;
    logic        I_reset_n;
    logic        I_en;
    logic [2:0]  I_op;
    logic [31:0] I_addr;
    logic [31:0] I_data;
    logic [31:0] O_data;
    logic        O_busy, O_valid, O_err, O_misaligned;
    logic [31:0] O_bus_addr, O_bus_data;
    logic        O_bus_strobe, O_bus_write, O_bus_halfword, O_bus_fullword;
    logic [31:0] I_bus_data;
    logic        I_bus_wait;
    lsu_state_t  O_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    spu32_cpu_lsu #(.ADDR_WIDTH(32), .TIMEOUT(4)) dut (
        .I_clk(I_clk), .I_reset_n(I_reset_n), .I_en(I_en), .I_op(I_op),
        .I_addr(I_addr), .I_data(I_data), .O_data(O_data), .O_busy(O_busy),
        .O_valid(O_valid), .O_err(O_err), .O_misaligned(O_misaligned),
        .O_bus_addr(O_bus_addr), .O_bus_data(O_bus_data), .O_bus_strobe(O_bus_strobe),
        .O_bus_write(O_bus_write), .O_bus_halfword(O_bus_halfword),
        .O_bus_fullword(O_bus_fullword), .I_bus_data(I_bus_data),
        .I_bus_wait(I_bus_wait), .O_state(O_state)
    );

    // clock / reset
    always #5 I_clk = ~I_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic tick();
        @(posedge I_clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        I_en = 1'b1; I_op = op; I_addr = addr; I_data = wdata;
        tick();
        I_en = 1'b0;
    endtask

    task automatic test_reset();
        I_reset_n = 1'b0; I_en = 1'b0; I_op = '0; I_addr = '0; I_data = '0;
        I_bus_data = '0; I_bus_wait = 1'b0;
        tick(); tick();
        checks++;
        if ({O_data, O_busy, O_valid, O_err, O_misaligned, O_bus_strobe, O_bus_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h busy=%b valid=%b strobe=%b addr=%h expected all zero",
                     O_data, O_busy, O_valid, O_bus_strobe, O_bus_addr);
        end
        // first edge after release accepts
        I_reset_n = 1'b1; I_bus_data = 32'h1234_5678;
        issue(BUSOP_READW, 32'h0000_0040, 32'h0);
        checks++;
        if ({O_bus_strobe, O_bus_fullword, O_bus_addr} !== {1'b1, 1'b1, 32'h40}) begin
            errors++;
            $display("FAIL reset_first_accept: got strobe=%b full=%b addr=%h expected 1 1 00000040",
                     O_bus_strobe, O_bus_fullword, O_bus_addr);
        end
        tick();
        checks++;
        if ({O_valid, O_data} !== {1'b1, 32'h1234_5678}) begin
            errors++;
            $display("FAIL reset_first_read: got valid=%b data=%h expected 1 12345678", O_valid, O_data);
        end
        tick();
    endtask

    task automatic test_readb_sign();
        I_bus_wait = 1'b0; I_bus_data = 32'h0000_00F0;
        issue(BUSOP_READB, 32'h0000_0103, 32'h0);
        checks++;
        if ({O_bus_strobe, O_valid, O_bus_addr, O_bus_write, O_bus_halfword, O_bus_fullword}
            !== {1'b1, 1'b0, 32'h103, 3'b000}) begin
            errors++;
            $display("FAIL readb_access: got strobe=%b valid=%b addr=%h w/h/f=%b%b%b expected 1 0 00000103 000",
                     O_bus_strobe, O_valid, O_bus_addr, O_bus_write, O_bus_halfword, O_bus_fullword);
        end
        tick();
        checks++;
        if ({O_valid, O_bus_strobe, O_data} !== {1'b1, 1'b0, 32'hFFFF_FFF0}) begin
            errors++;
            $display("FAIL readb_result: got valid=%b strobe=%b data=%h expected 1 0 fffffff0",
                     O_valid, O_bus_strobe, O_data);
        end
        tick();
        checks++;
        if ({O_valid, O_busy} !== 2'b00) begin
            errors++;
            $display("FAIL readb_idle: got valid=%b busy=%b expected 0 0", O_valid, O_busy);
        end
    endtask

    task automatic test_readhu_wait();
        int strobe_cycles = 0;
        I_bus_wait = 1'b1; I_bus_data = 32'hFFFF_8001;
        issue(BUSOP_READHU, 32'h0000_0200, 32'h0);
        for (int i = 0; i < 4; i++) begin
            if (O_bus_strobe && O_busy && O_bus_halfword && O_bus_addr == 32'h200) strobe_cycles++;
            if (i == 3) I_bus_wait = 1'b0;
            tick();
        end
        checks++;
        if (strobe_cycles !== 4) begin
            errors++;
            $display("FAIL readhu_strobe_cycles: got %0d expected 4", strobe_cycles);
        end
        checks++;
        if ({O_valid, O_busy, O_bus_strobe, O_data} !== {3'b110, 32'h0000_8001}) begin
            errors++;
            $display("FAIL readhu_result: got valid=%b busy=%b strobe=%b data=%h expected 1 1 0 00008001",
                     O_valid, O_busy, O_bus_strobe, O_data);
        end
        tick();
    endtask

    task automatic test_extend();
        logic [2:0]  ops [5];
        logic [31:0] exps [5];
        logic [31:0] exp_v;
        ops  = '{BUSOP_READB, BUSOP_READBU, BUSOP_READH, BUSOP_READHU, BUSOP_READW};
        exps = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8680, 32'h0000_8680, 32'h1234_8680};
        I_bus_wait = 1'b0; I_bus_data = 32'h1234_8680;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(exps[i]);
            issue(ops[i], 32'h0000_0300, 32'h0);
            tick();
            exp_v = exp_q.pop_front();
            checks++;
            if ({O_valid, O_data} !== {1'b1, exp_v}) begin
                errors++;
                $display("FAIL extend_op%0d: got valid=%b data=%h expected 1 %h", i, O_valid, O_data, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_write();
        logic [2:0]  ops   [3];
        logic [31:0] addrs [3];
        logic [1:0]  hf    [3];
        ops   = '{BUSOP_WRITEW, BUSOP_WRITEH, BUSOP_WRITEB};
        addrs = '{32'h400, 32'h402, 32'h403};
        hf    = '{2'b01, 2'b10, 2'b00};
        I_bus_wait = 1'b0; I_bus_data = 32'hDEAD_DEAD;
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], addrs[i], 32'hCAFE_BABE);
            checks++;
            if ({O_bus_strobe, O_bus_write, O_bus_halfword, O_bus_fullword, O_bus_addr, O_bus_data}
                !== {2'b11, hf[i], addrs[i], 32'hCAFE_BABE}) begin
                errors++;
                $display("FAIL write_bus%0d: got s/w/h/f=%b%b%b%b addr=%h data=%h expected 11%b %h cafebabe",
                         i, O_bus_strobe, O_bus_write, O_bus_halfword, O_bus_fullword,
                         O_bus_addr, O_bus_data, hf[i], addrs[i]);
            end
            tick();
            checks++;
            if ({O_valid, O_data} !== {1'b1, 32'h1234_8680}) begin
                errors++;
                $display("FAIL write_done%0d: got valid=%b data=%h expected 1 12348680", i, O_valid, O_data);
            end
            tick();
        end
    endtask

    task automatic test_misaligned();
`ifdef MISALIGN_SPLIT_EN
        logic [7:0] bytes_v [4];
        bytes_v = '{8'h11, 8'h22, 8'h33, 8'h44};
        I_bus_wait = 1'b0;
        issue(BUSOP_READW, 32'h0000_0101, 32'h0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({O_bus_strobe, O_bus_fullword, O_bus_addr} !== {2'b10, 32'h101 + k}) begin
                errors++;
                $display("FAIL split_beat%0d: got strobe=%b full=%b addr=%h expected 1 0 %h",
                         k, O_bus_strobe, O_bus_fullword, O_bus_addr, 32'h101 + k);
            end
            I_bus_data = {24'hAAAAAA, bytes_v[k]};
            tick();
            if (k < 3) tick();
        end
        checks++;
        if ({O_valid, O_data} !== {1'b1, 32'h4433_2211}) begin
            errors++;
            $display("FAIL split_result: got valid=%b data=%h expected 1 44332211", O_valid, O_data);
        end
        tick();
`else
        int strobe_seen = 0;
        I_bus_wait = 1'b0; I_bus_data = 32'h5555_5555;
        issue(BUSOP_READW, 32'h0000_0101, 32'h0);
        if (O_bus_strobe) strobe_seen++;
        checks++;
        if ({O_misaligned, O_valid, O_busy} !== 3'b101) begin
            errors++;
            $display("FAIL misaligned_pulse: got mis=%b valid=%b busy=%b expected 1 0 1",
                     O_misaligned, O_valid, O_busy);
        end
        tick();
        if (O_bus_strobe) strobe_seen++;
        checks++;
        if ({O_misaligned, O_busy, O_data} !== {2'b00, 32'h1234_8680}) begin
            errors++;
            $display("FAIL misaligned_end: got mis=%b busy=%b data=%h expected 0 0 12348680",
                     O_misaligned, O_busy, O_data);
        end
        issue(BUSOP_READH, 32'h0000_0201, 32'h0);
        if (O_bus_strobe) strobe_seen++;
        checks++;
        if ({O_misaligned, O_valid} !== 2'b10) begin
            errors++;
            $display("FAIL misaligned_half: got mis=%b valid=%b expected 1 0", O_misaligned, O_valid);
        end
        tick();
        checks++;
        if (strobe_seen !== 0) begin
            errors++;
            $display("FAIL misaligned_strobe: got %0d strobe cycles expected 0", strobe_seen);
        end
`endif
    endtask

    task automatic test_timeout();
        int strobe_cycles = 0;
        I_bus_wait = 1'b1;
        issue(BUSOP_READW, 32'h0000_0500, 32'h0);
        for (int i = 0; i < 4; i++) begin
            if (O_bus_strobe) strobe_cycles++;
            tick();
        end
        checks++;
        if (strobe_cycles !== 4) begin
            errors++;
            $display("FAIL timeout_strobe_cycles: got %0d expected 4", strobe_cycles);
        end
        checks++;
        if ({O_bus_strobe, O_err, O_valid, O_data} !== {3'b010, 32'h0}) begin
            errors++;
            $display("FAIL timeout_done: got strobe=%b err=%b valid=%b data=%h expected 0 1 0 00000000",
                     O_bus_strobe, O_err, O_valid, O_data);
        end
        tick();
        checks++;
        if ({O_err, O_busy} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_idle: got err=%b busy=%b expected 0 0", O_err, O_busy);
        end
        I_bus_wait = 1'b0;
    endtask

    task automatic test_reset_mid();
        int valid_seen = 0;
        I_bus_wait = 1'b1;
        issue(BUSOP_WRITEW, 32'h0000_0600, 32'h1111_1111);
        tick();
        #2 I_reset_n = 1'b0;
        #1;
        checks++;
        if ({O_bus_strobe, O_busy, O_valid, O_bus_addr, O_data} !== '0) begin
            errors++;
            $display("FAIL reset_mid_immediate: got strobe=%b busy=%b valid=%b addr=%h data=%h expected all zero",
                     O_bus_strobe, O_busy, O_valid, O_bus_addr, O_data);
        end
        I_bus_wait = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (O_valid) valid_seen++;
        end
        I_reset_n = 1'b1; I_bus_data = 32'h0BAD_F00D;
        issue(BUSOP_READW, 32'h0000_0700, 32'h0);
        checks++;
        if ({O_bus_strobe, O_bus_addr} !== {1'b1, 32'h700}) begin
            errors++;
            $display("FAIL reset_mid_accept: got strobe=%b addr=%h expected 1 00000700", O_bus_strobe, O_bus_addr);
        end
        tick();
        checks++;
        if ({O_valid, O_data, valid_seen} !== {1'b1, 32'h0BAD_F00D, 32'd0}) begin
            errors++;
            $display("FAIL reset_mid_result: got valid=%b data=%h stray_valid=%0d expected 1 0badf00d 0",
                     O_valid, O_data, valid_seen);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        I_bus_wait = 1'b1; I_bus_data = 32'h0000_00AB;
        issue(BUSOP_READBU, 32'h0000_0800, 32'h0);
        I_en = 1'b1; I_op = BUSOP_READW; I_addr = 32'h0000_0900;
        tick();
        checks++;
        if (O_bus_addr !== 32'h800) begin
            errors++;
            $display("FAIL busy_ignore: got addr=%h expected 00000800", O_bus_addr);
        end
        I_bus_wait = 1'b0;
        tick();
        checks++;
        if ({O_valid, O_data} !== {1'b1, 32'h0000_00AB}) begin
            errors++;
            $display("FAIL b2b_first: got valid=%b data=%h expected 1 000000ab", O_valid, O_data);
        end
        tick();
        checks++;
        if ({O_busy, O_bus_strobe} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_done_ignore: got busy=%b strobe=%b expected 0 0", O_busy, O_bus_strobe);
        end
        I_bus_data = 32'h7777_0001;
        tick();
        I_en = 1'b0;
        checks++;
        if ({O_bus_strobe, O_bus_addr} !== {1'b1, 32'h900}) begin
            errors++;
            $display("FAIL b2b_second_accept: got strobe=%b addr=%h expected 1 00000900", O_bus_strobe, O_bus_addr);
        end
        tick();
        checks++;
        if ({O_valid, O_data} !== {1'b1, 32'h7777_0001}) begin
            errors++;
            $display("FAIL b2b_second: got valid=%b data=%h expected 1 77770001", O_valid, O_data);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_readb_sign();
        test_readhu_wait();
        test_extend();
        test_write();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spu32_cpu_lsu.md
SPU32_CPU_LSU -- requirements
Module: spu32_cpu_lsu

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, bus address width (16..32).
REQ-002 SHALL have parameter TIMEOUT, default 255, max wait cycles per bus transaction; 0 disables the timeout.
REQ-003 SHALL have port I_clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port I_reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports I_en in 1 request; I_op in 3 busop code; I_addr in ADDR_WIDTH; I_data in 32 write operand.
REQ-006 SHALL have ports O_data out 32 extended read result; O_busy out 1; O_valid out 1 completion pulse; O_err out 1 timeout pulse; O_misaligned out 1 pulse.
REQ-007 SHALL have ports O_bus_addr out ADDR_WIDTH; O_bus_data out 32; O_bus_strobe, O_bus_write, O_bus_halfword, O_bus_fullword out 1; I_bus_data in 32; I_bus_wait in 1.

Function
REQ-008 SHALL accept a request at an edge where I_en=1 and state=IDLE; I_en while busy is ignored.
REQ-009 SHALL register op, address and operand at acceptance; O_bus_* outputs are registered, never combinational from I_*.
REQ-010 SHALL implement states IDLE, ACCESS, STEP, DONE; IDLE->ACCESS on accept; ACCESS->STEP on completion with beats remaining; STEP->ACCESS next cycle; ACCESS->DONE on last completion or timeout; DONE->IDLE unconditionally.
REQ-011 SHALL hold O_bus_strobe=1 and all bus outputs stable throughout ACCESS; strobe=0 in all other states.
REQ-012 SHALL treat a beat as complete at an edge in ACCESS with I_bus_wait=0, capturing I_bus_data that edge.
REQ-013 SHALL drive O_busy=1 in ACCESS, STEP, DONE; O_valid=1 for exactly the DONE cycle of a non-timed-out request.
REQ-014 Aligned access (byte any; half addr[0]=0; word addr[1:0]=0) SHALL be one beat with halfword/fullword/write flags per op; minimum latency accept->O_valid = 2 cycles with zero wait.
REQ-015 SHALL sign-extend READB from bit 7, READH from bit 15, zero-extend READBU/READHU, pass READW; O_data holds last result until next completion.
REQ-016 Writes SHALL set O_valid in DONE; O_data unchanged by writes.
REQ-017 SHALL count consecutive wait cycles per beat; when count reaches TIMEOUT (TIMEOUT>0) the beat aborts, strobe drops, state->DONE, O_err=1 and O_valid=0 in DONE, O_data=0.
REQ-018 Wait counter SHALL reset at every new beat and saturate, never wrap.

Reset
REQ-019 I_reset_n=0 SHALL force state IDLE and all outputs 0 (O_data=0, strobe=0) immediately, including mid-transaction; the pending request is discarded without O_valid.
REQ-020 First acceptance SHALL be possible at the first edge after reset deassertion.

Configuration
REQ-021 With MISALIGN_SPLIT_EN defined, a misaligned half/word SHALL execute as 2/4 byte beats at addr, addr+1..., little-endian; beat k reads into byte k / writes I_data byte k on O_bus_data[7:0]; extension applied after assembly; address increment wraps modulo 2^ADDR_WIDTH.
REQ-022 Without MISALIGN_SPLIT_EN, a misaligned request SHALL issue no bus beat, go IDLE->DONE, pulse O_misaligned with O_valid=0, O_data unchanged.
REQ-023 A timeout on any split beat SHALL abort remaining beats (REQ-017); completed write beats are not undone.

Structure
REQ-024 Shared package SHALL hold BUSOP_* codes, state encoding and a misalignment-test function; op codes shared with existing decode.
REQ-025 SHALL contain one sub-module spu32_cpu_lsu_extend (combinational op-driven sign/zero extension).

Verification
REQ-026 READB addr 0x103, bus data 0x000000F0, wait 0 -> O_valid 2 cycles after accept, O_data=0xFFFFFFF0.
REQ-027 READHU addr 0x200, wait high 3 cycles, data 0x8001 -> strobe 4 cycles, O_data=0x00008001, O_busy high throughout.
REQ-028 MISALIGN_SPLIT_EN: READW addr 0x101, bytes 11,22,33,44 -> 4 byte beats at 0x101..0x104, O_data=0x44332211; without macro -> O_misaligned pulse, no strobe.
REQ-029 TIMEOUT=4, I_bus_wait stuck 1 -> strobe low after 4 wait cycles, O_err pulse, O_valid 0, O_data=0.
REQ-030 I_reset_n low during WRITEW wait cycle 2 -> strobe 0 immediately, no O_valid; new READW accepted first edge after release.
